calc_seq_ctrl: RTL

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

---
 rtl/calc_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad calculator sequencer with 1-cycle add/sub and WIDTH-cycle shift-add multiply.
// Define CALC_SATURATE_EN to clamp overflowed results; default build wraps to the low WIDTH bits.
module calc_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       keypad_input,
  input  logic             read_input,
  input  logic             neg_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  input  logic             clear_input,
  output logic [WIDTH-1:0] display_output,
  output logic             complete,
  output logic             overflow,
  output logic             busy
);
  localparam logic [2:0] GET_FIRST  = 3'd0;
  localparam logic [2:0] GET_SECOND = 3'd1;
  localparam logic [2:0] EXEC_ALU   = 3'd2;
  localparam logic [2:0] EXEC_MULT  = 3'd3;
  localparam logic [2:0] SHOW       = 3'd4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [2:0]         state;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_a;
    logic               neg_b;
    logic [CW-1:0]      cnt;
    logic [2:0]         op;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [BW-1:0]      step;
    logic [WIDTH-1:0]   result;
    logic               ovf;
    logic               done;
  } regs_t;

  regs_t r, nx;

  logic [WIDTH-1:0]   cur_mag, sa, sb, alu_res, mul_res, m_wrap;
  logic               cur_neg, dig_ok, op_ok, alu_ovf, m_sign, m_ovf;
  logic [WIDTH+3:0]   new_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nx;

  assign cur_mag = r.state == GET_FIRST ? r.mag_a : r.mag_b;
  assign cur_neg = r.state == GET_FIRST ? r.neg_a : r.neg_b;
  assign new_mag = {4'b0, cur_mag} * (WIDTH+4)'(10) + (WIDTH+4)'(keypad_input);
  assign dig_ok  = read_input && keypad_input <= 4'd9 && r.cnt < CW'(MAX_DIGITS) && new_mag <= (WIDTH+4)'(MAX_POS);
  assign op_ok   = operator_input inside {3'b001, 3'b010, 3'b100};
  assign sa      = r.neg_a ? -r.mag_a : r.mag_a;
  assign sb      = r.neg_b ? -r.mag_b : r.mag_b;
  assign sum     = r.op == 3'b010 ? {sa[WIDTH-1], sa} - {sb[WIDTH-1], sb} : {sa[WIDTH-1], sa} + {sb[WIDTH-1], sb};
  assign alu_ovf = sum[WIDTH] ^ sum[WIDTH-1];
  assign prod_nx = r.prod + (r.mplier[0] ? r.mcand : '0);
  assign m_sign  = r.neg_a ^ r.neg_b;
  // A negative product may reach magnitude 2^(WIDTH-1); a positive one may not.
  assign m_ovf   = m_sign ? prod_nx > {{WIDTH{1'b0}}, MIN_NEG} : prod_nx > {{WIDTH{1'b0}}, MAX_POS};
  assign m_wrap  = m_sign ? -prod_nx[WIDTH-1:0] : prod_nx[WIDTH-1:0];
`ifdef CALC_SATURATE_EN
  assign alu_res = alu_ovf ? (sum[WIDTH] ? MIN_NEG : MAX_POS) : sum[WIDTH-1:0];
  assign mul_res = m_ovf ? (m_sign ? MIN_NEG : MAX_POS) : m_wrap;
`else
  assign alu_res = sum[WIDTH-1:0];
  assign mul_res = m_wrap;
`endif

  always_comb begin
    nx      = r;
    nx.done = 1'b0;
    case (r.state)
      GET_FIRST, GET_SECOND: begin
        if (dig_ok) begin
          nx.cnt = r.cnt + CW'(1);
          if (r.state == GET_FIRST) nx.mag_a = new_mag[WIDTH-1:0];
          else nx.mag_b = new_mag[WIDTH-1:0];
        end
        if (neg_input && r.state == GET_FIRST) nx.neg_a = ~r.neg_a;
        if (neg_input && r.state == GET_SECOND) nx.neg_b = ~r.neg_b;
        if (r.state == GET_FIRST && op_ok) begin
          nx.op    = operator_input;
          nx.state = GET_SECOND;
          nx.cnt   = '0;
        end
        if (r.state == GET_SECOND && equal_input && !read_input) begin
          nx.state  = r.op == 3'b100 ? EXEC_MULT : EXEC_ALU;
          nx.prod   = '0;
          nx.mcand  = {{WIDTH{1'b0}}, r.mag_a};
          nx.mplier = r.mag_b;
          nx.step   = '0;
        end
      end
      EXEC_ALU: begin
        nx.result = alu_res;
        nx.ovf    = alu_ovf;
        nx.state  = SHOW;
      end
      EXEC_MULT: begin
        nx.prod   = prod_nx;
        nx.mcand  = r.mcand << 1;
        nx.mplier = r.mplier >> 1;
        nx.step   = r.step + BW'(1);
        if (r.step == BW'(WIDTH-1)) begin
          nx.result = mul_res;
          nx.ovf    = m_ovf;
          nx.state  = SHOW;
        end
      end
      SHOW: begin
        if (read_input && keypad_input <= 4'd9) begin
          nx       = '0;
          nx.mag_a = WIDTH'(keypad_input);
          nx.cnt   = CW'(1);
        end else nx.done = 1'b1;
      end
      default: nx = '0;
    endcase
    if (clear_input) nx = '0;
  end

  always_ff @(posedge clk or negedge nRST)
    if (!nRST) r <= '0;
    else r <= nx;

  assign display_output = r.state == SHOW ? r.result : (cur_neg ? -cur_mag : cur_mag);
  assign complete       = r.done;
  assign overflow       = r.done & r.ovf;
  assign busy           = r.state == EXEC_ALU || r.state == EXEC_MULT;
endmodule
